// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    localparam int unsigned BcdW      = 4;
    localparam logic [3:0]  AddThresh = 4'd5;
    localparam logic [3:0]  SatDigit  = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BcdW-1:0] digit,
    output logic [BcdW-1:0] adjusted
);

    assign adjusted = (digit >= AddThresh) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BCD_SIGNED_EN to treat in_bin as two's complement and add the out_neg port.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 17,
    parameter int unsigned DIGITS = 6
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BcdW*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]      out_blank,
    output logic                   out_ovf
`ifdef BCD_SIGNED_EN
    ,
    output logic                   out_neg
`endif
);

    localparam int unsigned DW   = BcdW * DIGITS;
    localparam int unsigned CntW = $clog2(IN_W + 1);

    state_t          state;
    logic [IN_W-1:0] opnd_q;
    logic [DW-1:0]   digits_q;
    logic [DW-1:0]   adj;
    logic [CntW-1:0] cnt_q;
    logic            sticky_q;
    logic [IN_W-1:0] mag;
    logic [DIGITS-1:0] blank_c;

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

`ifdef BCD_SIGNED_EN
    logic neg_q;
    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign mag = in_bin[IN_W-1] ? -in_bin : in_bin;
`else
    assign mag = in_bin;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (digits_q[BcdW*g +: BcdW]),
            .adjusted (adj[BcdW*g +: BcdW])
        );
    end

    // Digit i is blank when it and every higher digit are zero; the units digit never blanks.
    always_comb begin
        logic nz;
        nz      = 1'b0;
        blank_c = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz         = nz | (digits_q[BcdW*i +: BcdW] != '0);
            blank_c[i] = ~nz;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= StIdle;
            opnd_q    <= '0;
            digits_q  <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            out_bcd   <= '0;
            out_blank <= '0;
            out_ovf   <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg_q     <= 1'b0;
            out_neg   <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        opnd_q   <= mag;
                        digits_q <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= CntW'(IN_W);
                        state    <= StShift;
`ifdef BCD_SIGNED_EN
                        neg_q    <= in_bin[IN_W-1];
`endif
                    end
                end
                StShift: begin
                    if (cnt_q != '0) begin
                        digits_q <= {adj[DW-2:0], opnd_q[IN_W-1]};
                        opnd_q   <= opnd_q << 1;
                        sticky_q <= sticky_q | adj[DW-1];
                        cnt_q    <= cnt_q - CntW'(1);
                    end else begin
                        state     <= StDone;
                        out_ovf   <= sticky_q;
                        out_bcd   <= sticky_q ? {DIGITS{SatDigit}} : digits_q;
                        out_blank <= sticky_q ? '0 : blank_c;
`ifdef BCD_SIGNED_EN
                        out_neg   <= neg_q;
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (6-digit main instance, 5-digit overflow instance).
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_bcd;
    logic [5:0]  out_blank;
    logic        out_ovf;

    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic [17:0] in_bin5 = '0;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;
    logic [19:0] out_bcd5;
    logic [4:0]  out_blank5;
    logic        out_ovf5;

`ifdef BCD_SIGNED_EN
    logic        out_neg;
    logic        out_neg5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.IN_W(17), .DIGITS(6)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_blank (out_blank),
        .out_ovf   (out_ovf)
`ifdef BCD_SIGNED_EN
        ,
        .out_neg   (out_neg)
`endif
    );

    bin2bcd_seq #(.IN_W(18), .DIGITS(5)) dut5 (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .in_bin    (in_bin5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_bcd   (out_bcd5),
        .out_blank (out_blank5),
        .out_ovf   (out_ovf5)
`ifdef BCD_SIGNED_EN
        ,
        .out_neg   (out_neg5)
`endif
    );

    task automatic start(input logic [16:0] v);
        @(negedge clk);
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic release_result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [32:0] got;
        clr_n = 1'b0;
        #1;
        got = {in_ready, out_valid, out_bcd, out_blank, out_ovf};
        checks++;
        if (got !== {1'b1, 1'b0, 24'h0, 6'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, {1'b1, 1'b0, 24'h0, 6'h0, 1'b0});
        end
        checks++;
        if ({in_ready5, out_valid5, out_ovf5} !== 3'b100) begin
            errors++;
            $display("FAIL reset_state5: got %b expected 100", {in_ready5, out_valid5, out_ovf5});
        end
`ifdef BCD_SIGNED_EN
        checks++;
        if (out_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset_neg: got %b expected 0", out_neg);
        end
`endif
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_max_latency;
        logic [23:0] exp_bcd;
        logic [5:0]  exp_blank;
`ifdef BCD_SIGNED_EN
        exp_bcd   = 24'h000001;
        exp_blank = 6'b111110;
`else
        exp_bcd   = 24'h131071;
        exp_blank = 6'b000000;
`endif
        start(17'd131071);
        in_valid = 1'b1;
        in_bin   = 17'd5;
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL latency_early: got valid/ready %b expected 00", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_blank, out_ovf} !== {1'b1, exp_bcd, exp_blank, 1'b0}) begin
            errors++;
            $display("FAIL max_value: got v=%b bcd=%h blank=%b ovf=%b expected bcd=%h blank=%b",
                     out_valid, out_bcd, out_blank, out_ovf, exp_bcd, exp_blank);
        end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_small;
        start(17'd0);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_blank, out_ovf} !== {1'b1, 24'h000000, 6'b111110, 1'b0}) begin
            errors++;
            $display("FAIL zero: got v=%b bcd=%h blank=%b ovf=%b expected bcd=000000 blank=111110",
                     out_valid, out_bcd, out_blank, out_ovf);
        end
        release_result();
        start(17'd7);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_blank, out_ovf} !== {1'b1, 24'h000007, 6'b111110, 1'b0}) begin
            errors++;
            $display("FAIL seven: got v=%b bcd=%h blank=%b ovf=%b expected bcd=000007 blank=111110",
                     out_valid, out_bcd, out_blank, out_ovf);
        end
        release_result();
    endtask

    task automatic test_overflow;
        @(negedge clk);
        in_bin5   = 18'd100000;
        in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if (out_valid5 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_latency: got valid %b expected 0", out_valid5);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid5, out_bcd5, out_blank5, out_ovf5} !== {1'b1, 20'h99999, 5'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow: got v=%b bcd=%h blank=%b ovf=%b expected bcd=99999 blank=0 ovf=1",
                     out_valid5, out_bcd5, out_blank5, out_ovf5);
        end
        @(negedge clk);
        out_ready5 = 1'b1;
        @(posedge clk);
        #1;
        out_ready5 = 1'b0;
    endtask

    task automatic test_back_pressure;
        start(17'd4095);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_blank} !== {1'b1, 24'h004095, 6'b110000}) begin
            errors++;
            $display("FAIL bp_result: got v=%b bcd=%h blank=%b expected bcd=004095 blank=110000",
                     out_valid, out_bcd, out_blank);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bin   = 17'd1;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, out_bcd, out_blank} !== {2'b10, 24'h004095, 6'b110000}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%b bcd=%h blank=%b expected v=1 r=0 bcd=004095",
                         i, out_valid, in_ready, out_bcd, out_blank);
            end
        end
        in_valid = 1'b0;
        release_result();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got valid/ready %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid_run;
        int seen;
        start(17'd99999);
        repeat (9) @(posedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_bcd, out_blank, out_ovf} !== {2'b10, 24'h0, 6'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got r=%b v=%b bcd=%h blank=%b ovf=%b expected all zero, ready 1",
                     in_ready, out_valid, out_bcd, out_blank, out_ovf);
        end
        @(negedge clk);
        clr_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_abandon: got %0d valid cycles expected 0", seen);
        end
        start(17'd12345);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_blank, out_ovf} !== {1'b1, 24'h012345, 6'b100000, 1'b0}) begin
            errors++;
            $display("FAIL after_reset: got v=%b bcd=%h blank=%b ovf=%b expected bcd=012345 blank=100000",
                     out_valid, out_bcd, out_blank, out_ovf);
        end
        release_result();
    endtask

`ifdef BCD_SIGNED_EN
    task automatic test_signed;
        start(17'h1FB2E);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_neg} !== {1'b1, 24'h001234, 1'b1}) begin
            errors++;
            $display("FAIL neg_1234: got v=%b bcd=%h neg=%b expected bcd=001234 neg=1",
                     out_valid, out_bcd, out_neg);
        end
        release_result();
        start(17'h10000);
        repeat (18) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_bcd, out_neg} !== {1'b1, 24'h065536, 1'b1}) begin
            errors++;
            $display("FAIL neg_min: got v=%b bcd=%h neg=%b expected bcd=065536 neg=1",
                     out_valid, out_bcd, out_neg);
        end
        release_result();
    endtask
`endif

    initial begin
        test_reset();
        test_max_latency();
        test_small();
        test_overflow();
        test_back_pressure();
        test_reset_mid_run();
`ifdef BCD_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
